// File: rtl/dmem_responder.sv
// Single-outstanding RV32I data-memory responder with load/store width decode and configurable wait states.
// Optional build macro DMEM_MISALIGN_TRAP_EN: defined -> misaligned accesses error out; undefined -> they are force-aligned.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [3:0]      wait_cnt_r;
    logic            req_ready_r;
    logic            rsp_valid_r;
    logic [31:0]     rsp_rdata_r;
    logic            rsp_err_r;

    logic            we_r;
    logic [AW+1:0]   addr_r;
    logic [31:0]     wdata_r;
    logic [2:0]      funct3_r;

    logic            acc_we_s;
    logic [AW+1:0]   acc_addr_s;
    logic [31:0]     acc_wdata_s;
    logic [2:0]      acc_funct3_s;

    logic            accept_s;
    logic            enter_resp_s;
    logic            commit_s;
    logic            f3_ok_s;
    logic            misalign_s;
    logic            err_s;
    logic [AW+1:0]   eff_addr_s;
    logic [AW-1:0]   word_idx_s;
    logic [1:0]      byte_off_s;
    logic [31:0]     rd_word_s;
    logic [31:0]     load_data_s;
    logic [31:0]     store_word_s;
    logic            unused_addr_s;

    logic [31:0]     mem_r [DEPTH_WORDS];

    // Sign/zero-extend the addressed lane of a fetched word.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b010:  load_extend = word;
            3'b100:  load_extend = {24'd0, b};
            3'b101:  load_extend = {16'd0, h};
            default: load_extend = 32'd0;
        endcase
    endfunction

    // Merge store data into the old word, touching only the addressed lanes.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0] res;
        res = old;
        case (f3)
            3'b000:  res[{off, 3'b000} +: 8] = wdata[7:0];
            3'b001: begin
                if (off[1]) begin
                    res[31:16] = wdata[15:0];
                end else begin
                    res[15:0] = wdata[15:0];
                end
            end
            3'b010:  res = wdata;
            default: res = old;
        endcase
        return res;
    endfunction

    assign unused_addr_s = ^req_addr[31:AW+2];

    assign accept_s     = req_valid && req_ready_r;
    assign enter_resp_s = ((state_r == IDLE) && accept_s && NO_WAIT) ||
                          ((state_r == WAIT) && (wait_cnt_r == 4'd0));

    // With zero wait states the access executes straight off the request bus.
    assign acc_we_s     = (state_r == IDLE) ? req_we            : we_r;
    assign acc_addr_s   = (state_r == IDLE) ? req_addr[AW+1:0]  : addr_r;
    assign acc_wdata_s  = (state_r == IDLE) ? req_wdata         : wdata_r;
    assign acc_funct3_s = (state_r == IDLE) ? req_funct3        : funct3_r;

    // Classify the access: legal funct3, alignment, and effective address.
    always_comb begin
        f3_ok_s    = 1'b0;
        misalign_s = 1'b0;
        eff_addr_s = acc_addr_s;
        err_s      = 1'b0;
        case (acc_funct3_s)
            3'b000: f3_ok_s = 1'b1;
            3'b001: begin
                f3_ok_s    = 1'b1;
                misalign_s = acc_addr_s[0];
            end
            3'b010: begin
                f3_ok_s    = 1'b1;
                misalign_s = |acc_addr_s[1:0];
            end
            3'b100: f3_ok_s = !acc_we_s;
            3'b101: begin
                f3_ok_s    = !acc_we_s;
                misalign_s = acc_addr_s[0];
            end
            default: f3_ok_s = 1'b0;
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        err_s = !f3_ok_s || misalign_s;
`else
        err_s = !f3_ok_s;
        if (misalign_s) begin
            if (acc_funct3_s[1]) begin
                eff_addr_s[1:0] = 2'b00;
            end else begin
                eff_addr_s[0] = 1'b0;
            end
        end else begin
            eff_addr_s = acc_addr_s;
        end
`endif
    end

    assign word_idx_s   = eff_addr_s[AW+1:2];
    assign byte_off_s   = eff_addr_s[1:0];
    assign rd_word_s    = mem_r[word_idx_s];
    assign load_data_s  = load_extend(rd_word_s, byte_off_s, acc_funct3_s);
    assign store_word_s = store_merge(rd_word_s, acc_wdata_s, byte_off_s, acc_funct3_s);
    assign commit_s     = enter_resp_s && acc_we_s && !err_s;

    // Next-state logic for the IDLE -> WAIT -> RESP handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = NO_WAIT ? RESP : WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register; req_ready is registered so it stays low through reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            req_ready_r <= (state_next_s == IDLE);
        end
    end

    // Request capture and wait-state countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= 32'd0;
            funct3_r   <= 3'd0;
            wait_cnt_r <= 4'd0;
        end else if (accept_s) begin
            we_r       <= req_we;
            addr_r     <= req_addr[AW+1:0];
            wdata_r    <= req_wdata;
            funct3_r   <= req_funct3;
            wait_cnt_r <= WAIT_LOAD;
        end else if ((state_r == WAIT) && (wait_cnt_r != 4'd0)) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end
    end

    // Response registers, held stable until the core takes them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end else if (enter_resp_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= err_s;
            rsp_rdata_r <= (acc_we_s || err_s) ? 32'd0 : load_data_s;
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end
    end

    // Storage array; never cleared, and a store racing reset is dropped.
    always_ff @(posedge clk) begin
        if (commit_s && !reset) begin
            mem_r[word_idx_s] <= store_word_s;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES=2, DEPTH_WORDS=1024).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, latency, optional back-pressure, handshake, return to idle.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3, input int hold,
                          output logic [31:0] rdata, output logic err);
        int lat;
        int guard;
        @(negedge clk);
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        req_valid  = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        check_eq({tag, " latency"}, lat, 32'd3);
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, " hold valid"}, {31'd0, rsp_valid}, 32'd1);
            check_eq({tag, " hold rdata"}, rsp_rdata, rdata);
            check_eq({tag, " hold ready"}, {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, " idle ready"}, {31'd0, req_ready}, 32'd1);
        check_eq({tag, " idle valid"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3, input int hold,
                       input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        do_req(tag, we, addr, wdata, f3, hold, rd, er);
        check_eq({tag, " rdata"}, rd, exp_rdata);
        check_eq({tag, " err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_funct3 = 3'd0;
        rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst req_ready", {31'd0, req_ready}, 32'd0);
        check_eq("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst rsp_err", {31'd0, rsp_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post-rst req_ready", {31'd0, req_ready}, 32'd1);

        txn("SW 0x10",  1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 32'h0, 1'b0);
        txn("LW 0x10",  1'b0, 32'h10, 32'h0,        3'b010, 0, 32'hDEADBEEF, 1'b0);
        txn("SB 0x11",  1'b1, 32'h11, 32'h000000AA, 3'b000, 0, 32'h0, 1'b0);
        txn("LW hold",  1'b0, 32'h10, 32'h0,        3'b010, 5, 32'hDEADAAEF, 1'b0);
        txn("LB 0x11",  1'b0, 32'h11, 32'h0,        3'b000, 0, 32'hFFFFFFAA, 1'b0);
        txn("LBU 0x11", 1'b0, 32'h11, 32'h0,        3'b100, 0, 32'h000000AA, 1'b0);
        txn("LHU 0x12", 1'b0, 32'h12, 32'h0,        3'b101, 0, 32'h0000DEAD, 1'b0);
        txn("LH 0x12",  1'b0, 32'h12, 32'h0,        3'b001, 0, 32'hFFFFDEAD, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        txn("LW 0x12 mis", 1'b0, 32'h12, 32'h0, 3'b010, 0, 32'h0, 1'b1);
`else
        txn("LW 0x12 mis", 1'b0, 32'h12, 32'h0, 3'b010, 0, 32'hDEADAAEF, 1'b0);
`endif
        txn("LD f3=011", 1'b0, 32'h10, 32'h0,        3'b011, 0, 32'h0, 1'b1);
        txn("ST f3=011", 1'b1, 32'h10, 32'h00000000, 3'b011, 0, 32'h0, 1'b1);
        txn("LW no-wr",  1'b0, 32'h10, 32'h0,        3'b010, 0, 32'hDEADAAEF, 1'b0);
        txn("SH 0x12",   1'b1, 32'h12, 32'hFFFF1234, 3'b001, 0, 32'h0, 1'b0);
        txn("LW SH",     1'b0, 32'h10, 32'h0,        3'b010, 0, 32'h1234AAEF, 1'b0);
        txn("SW 0x20",   1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 0, 32'h0, 1'b0);

        // Store aborted by reset while waiting must leave memory untouched.
        @(negedge clk);
        req_we     = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = 32'h12345678;
        req_funct3 = 3'b010;
        req_valid  = 1'b1;
        check_eq("abort req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort rst ready", {31'd0, req_ready}, 32'd0);
        check_eq("abort rst valid", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort post ready", {31'd0, req_ready}, 32'd1);
        check_eq("abort post valid", {31'd0, rsp_valid}, 32'd0);
        txn("LW 0x20",   1'b0, 32'h20, 32'h0, 3'b010, 0, 32'hCAFEF00D, 1'b0);

        txn("SW 0x1000", 1'b1, 32'h1000, 32'h0BADF00D, 3'b010, 0, 32'h0, 1'b0);
        txn("LW wrap",   1'b0, 32'h0,    32'h0,        3'b010, 0, 32'h0BADF00D, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
